// File: rtl/fpnew_noncomp_sched_pkg.sv
// Shared types for the non-computational FP unit scheduler: the unit's operation,
// rounding, status and class-mask encodings, plus the requester-ID width helper.
package fpnew_noncomp_sched_pkg;

  localparam int unsigned SCHED_CNT_W  = 4;
  localparam int unsigned SCHED_STAT_W = 16;

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4,
    ROD = 3'd5,
    DYN = 3'd7
  } roundmode_e;

  typedef enum logic [3:0] {
    FMADD    = 4'd0,
    FNMSUB   = 4'd1,
    ADD      = 4'd2,
    MUL      = 4'd3,
    DIV      = 4'd4,
    SQRT     = 4'd5,
    SGNJ     = 4'd6,
    MINMAX   = 4'd7,
    CMP      = 4'd8,
    CLASSIFY = 4'd9,
    F2F      = 4'd10,
    F2I      = 4'd11,
    I2F      = 4'd12,
    CPKAB    = 4'd13,
    CPKCD    = 4'd14
  } operation_e;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

  typedef enum logic [9:0] {
    NEGINF     = 10'h001,
    NEGNORM    = 10'h002,
    NEGSUBNORM = 10'h004,
    NEGZERO    = 10'h008,
    POSZERO    = 10'h010,
    POSSUBNORM = 10'h020,
    POSNORM    = 10'h040,
    POSINF     = 10'h080,
    SNAN       = 10'h100,
    QNAN       = 10'h200
  } classmask_e;

  function automatic int unsigned sched_id_width(int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/fpnew_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr_i,
// wrapping modulo NumReq.
module fpnew_rr_arbiter #(
  parameter int unsigned NumReq = 2,
  parameter int unsigned IdW    = 1
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdW-1:0]    rr_ptr_i,
  output logic [IdW-1:0]    gnt_id_o,
  output logic              valid_o
);

  always_comb begin
    logic [IdW-1:0] idx;
    gnt_id_o = '0;
    valid_o  = 1'b0;
    idx      = '0;
    for (int unsigned off = 0; off < NumReq; off++) begin
      idx = IdW'((32'(rr_ptr_i) + off) % NumReq);
      if (!valid_o && req_i[idx]) begin
        valid_o  = 1'b1;
        gnt_id_o = idx;
      end
    end
  end

endmodule

// File: rtl/fpnew_noncomp_sched.sv
// Round-robin sharing of one non-computational FP unit between NumReq requesters,
// with grant lock under backpressure, credit limiting and tag-based response routing.
// Optional statistics counters: FPNEW_NONCOMP_SCHED_STATS_EN.
module fpnew_noncomp_sched
  import fpnew_noncomp_sched_pkg::*;
#(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned Width          = 32,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned IdW           = sched_id_width(NumReq)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               flush_i,
  input  logic [NumReq-1:0]                  req_valid_i,
  output logic [NumReq-1:0]                  req_ready_o,
  input  logic [NumReq-1:0][1:0][Width-1:0]  req_operands_i,
  input  logic [NumReq-1:0][1:0]             req_is_boxed_i,
  input  roundmode_e [NumReq-1:0]            req_rnd_mode_i,
  input  operation_e [NumReq-1:0]            req_op_i,
  input  logic [NumReq-1:0]                  req_op_mod_i,
  output logic [1:0][Width-1:0]              unit_operands_o,
  output logic [1:0]                         unit_is_boxed_o,
  output roundmode_e                         unit_rnd_mode_o,
  output operation_e                         unit_op_o,
  output logic                               unit_op_mod_o,
  output logic [IdW-1:0]                     unit_tag_o,
  output logic                               unit_in_valid_o,
  input  logic                               unit_in_ready_i,
  input  logic [Width-1:0]                   unit_result_i,
  input  status_t                            unit_status_i,
  input  logic                               unit_ext_bit_i,
  input  classmask_e                         unit_class_mask_i,
  input  logic                               unit_is_class_i,
  input  logic [IdW-1:0]                     unit_tag_i,
  input  logic                               unit_out_valid_i,
  output logic                               unit_out_ready_o,
  output logic [NumReq-1:0]                  rsp_valid_o,
  input  logic [NumReq-1:0]                  rsp_ready_i,
  output logic [Width-1:0]                   rsp_result_o,
  output status_t                            rsp_status_o,
  output logic                               rsp_ext_bit_o,
  output classmask_e                         rsp_class_mask_o,
  output logic                               rsp_is_class_o,
  output logic                               busy_o
`ifdef FPNEW_NONCOMP_SCHED_STATS_EN
  ,
  output logic [NumReq-1:0][SCHED_STAT_W-1:0] grant_cnt_o,
  output logic [SCHED_STAT_W-1:0]             stall_cnt_o
`endif
);

  typedef struct packed {
    logic [1:0][Width-1:0] operands;
    logic [1:0]            is_boxed;
    roundmode_e            rnd_mode;
    operation_e            op;
    logic                  op_mod;
  } sched_req_t;

  logic [IdW-1:0]         rr_ptr_q, rr_ptr_d;
  logic                   lock_q, lock_d;
  logic [IdW-1:0]         lock_id_q, lock_id_d;
  logic [SCHED_CNT_W-1:0] cnt_q, cnt_d;

  logic [IdW-1:0] arb_id, gnt;
  logic           arb_valid, gnt_valid;
  logic           issue_ok, issue_hs, retire_hs;
  sched_req_t     gnt_req;

  fpnew_rr_arbiter #(
    .NumReq (NumReq),
    .IdW    (IdW)
  ) i_arbiter (
    .req_i    (req_valid_i),
    .rr_ptr_i (rr_ptr_q),
    .gnt_id_o (arb_id),
    .valid_o  (arb_valid)
  );

  assign issue_ok  = (cnt_q < SCHED_CNT_W'(MaxOutstanding));
  assign gnt       = lock_q ? lock_id_q : arb_id;
  assign gnt_valid = lock_q ? req_valid_i[lock_id_q] : arb_valid;

  assign gnt_req.operands = req_operands_i[gnt];
  assign gnt_req.is_boxed = req_is_boxed_i[gnt];
  assign gnt_req.rnd_mode = req_rnd_mode_i[gnt];
  assign gnt_req.op       = req_op_i[gnt];
  assign gnt_req.op_mod   = req_op_mod_i[gnt];

  assign unit_operands_o = gnt_req.operands;
  assign unit_is_boxed_o = gnt_req.is_boxed;
  assign unit_rnd_mode_o = gnt_req.rnd_mode;
  assign unit_op_o       = gnt_req.op;
  assign unit_op_mod_o   = gnt_req.op_mod;
  assign unit_tag_o      = gnt;

  // Handshake outputs are qualified by rst_ni so they read 0 while reset is held.
  assign unit_in_valid_o  = rst_ni & !flush_i & issue_ok & gnt_valid;
  assign issue_hs         = unit_in_valid_o & unit_in_ready_i;
  assign unit_out_ready_o = rst_ni & rsp_ready_i[unit_tag_i];
  assign retire_hs        = unit_out_valid_i & unit_out_ready_o;

  always_comb begin
    req_ready_o = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      req_ready_o[i] = rst_ni & !flush_i & issue_ok & unit_in_ready_i & (gnt == IdW'(i));
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      rsp_valid_o[i] = rst_ni & unit_out_valid_i & (unit_tag_i == IdW'(i));
    end
  end

  assign rsp_result_o     = unit_result_i;
  assign rsp_status_o     = unit_status_i;
  assign rsp_ext_bit_o    = unit_ext_bit_i;
  assign rsp_class_mask_o = unit_class_mask_i;
  assign rsp_is_class_o   = unit_is_class_i;

  assign busy_o = (cnt_q != '0) | lock_q;

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    cnt_d     = cnt_q;
    if (flush_i) begin
      lock_d = 1'b0;
      cnt_d  = '0;
    end else begin
      if (issue_hs) begin
        rr_ptr_d = (gnt == IdW'(NumReq - 1)) ? '0 : gnt + 1'b1;
        lock_d   = 1'b0;
      end else if (unit_in_valid_o) begin
        lock_d    = 1'b1;
        lock_id_d = gnt;
      end
      case ({issue_hs, retire_hs})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q  <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      cnt_q     <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef FPNEW_NONCOMP_SCHED_STATS_EN
  logic [NumReq-1:0][SCHED_STAT_W-1:0] grant_cnt_q;
  logic [SCHED_STAT_W-1:0]             stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NumReq; i++) begin
        if (issue_hs && (gnt == IdW'(i)) && (grant_cnt_q[i] != '1)) begin
          grant_cnt_q[i] <= grant_cnt_q[i] + 1'b1;
        end
      end
      if ((|req_valid_i) && !issue_ok && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign grant_cnt_o = grant_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

  a_tag_legal : assert property (@(posedge clk_i) disable iff (!rst_ni)
    unit_out_valid_i |-> (32'(unit_tag_i) < NumReq));
  a_rsp_has_credit : assert property (@(posedge clk_i) disable iff (!rst_ni)
    unit_out_valid_i |-> (cnt_q != '0));

endmodule

// File: tb/tb_fpnew_noncomp_sched.sv
// Directed bench for fpnew_noncomp_sched (NumReq=2, MaxOutstanding=4); the unit side
// is driven directly by the stimulus.
module tb_fpnew_noncomp_sched;
  import fpnew_noncomp_sched_pkg::*;

  logic                       clk_i = 1'b0;
  logic                       rst_ni;
  logic                       flush_i;
  logic [1:0]                 req_valid_i;
  logic [1:0]                 req_ready_o;
  logic [1:0][1:0][31:0]      req_operands_i;
  logic [1:0][1:0]            req_is_boxed_i;
  roundmode_e [1:0]           req_rnd_mode_i;
  operation_e [1:0]           req_op_i;
  logic [1:0]                 req_op_mod_i;
  logic [1:0][31:0]           unit_operands_o;
  logic [1:0]                 unit_is_boxed_o;
  roundmode_e                 unit_rnd_mode_o;
  operation_e                 unit_op_o;
  logic                       unit_op_mod_o;
  logic                       unit_tag_o;
  logic                       unit_in_valid_o;
  logic                       unit_in_ready_i;
  logic [31:0]                unit_result_i;
  status_t                    unit_status_i;
  logic                       unit_ext_bit_i;
  classmask_e                 unit_class_mask_i;
  logic                       unit_is_class_i;
  logic                       unit_tag_i;
  logic                       unit_out_valid_i;
  logic                       unit_out_ready_o;
  logic [1:0]                 rsp_valid_o;
  logic [1:0]                 rsp_ready_i;
  logic [31:0]                rsp_result_o;
  status_t                    rsp_status_o;
  logic                       rsp_ext_bit_o;
  classmask_e                 rsp_class_mask_o;
  logic                       rsp_is_class_o;
  logic                       busy_o;
`ifdef FPNEW_NONCOMP_SCHED_STATS_EN
  logic [1:0][15:0]           grant_cnt_o;
  logic [15:0]                stall_cnt_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  fpnew_noncomp_sched #(
    .NumReq         (2),
    .Width          (32),
    .MaxOutstanding (4)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .flush_i           (flush_i),
    .req_valid_i       (req_valid_i),
    .req_ready_o       (req_ready_o),
    .req_operands_i    (req_operands_i),
    .req_is_boxed_i    (req_is_boxed_i),
    .req_rnd_mode_i    (req_rnd_mode_i),
    .req_op_i          (req_op_i),
    .req_op_mod_i      (req_op_mod_i),
    .unit_operands_o   (unit_operands_o),
    .unit_is_boxed_o   (unit_is_boxed_o),
    .unit_rnd_mode_o   (unit_rnd_mode_o),
    .unit_op_o         (unit_op_o),
    .unit_op_mod_o     (unit_op_mod_o),
    .unit_tag_o        (unit_tag_o),
    .unit_in_valid_o   (unit_in_valid_o),
    .unit_in_ready_i   (unit_in_ready_i),
    .unit_result_i     (unit_result_i),
    .unit_status_i     (unit_status_i),
    .unit_ext_bit_i    (unit_ext_bit_i),
    .unit_class_mask_i (unit_class_mask_i),
    .unit_is_class_i   (unit_is_class_i),
    .unit_tag_i        (unit_tag_i),
    .unit_out_valid_i  (unit_out_valid_i),
    .unit_out_ready_o  (unit_out_ready_o),
    .rsp_valid_o       (rsp_valid_o),
    .rsp_ready_i       (rsp_ready_i),
    .rsp_result_o      (rsp_result_o),
    .rsp_status_o      (rsp_status_o),
    .rsp_ext_bit_o     (rsp_ext_bit_o),
    .rsp_class_mask_o  (rsp_class_mask_o),
    .rsp_is_class_o    (rsp_is_class_o),
    .busy_o            (busy_o)
`ifdef FPNEW_NONCOMP_SCHED_STATS_EN
    ,
    .grant_cnt_o       (grant_cnt_o),
    .stall_cnt_o       (stall_cnt_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp_tag;

    rst_ni            = 1'b0;
    flush_i           = 1'b0;
    req_valid_i       = 2'b00;
    req_operands_i[0] = {32'hB000_0000, 32'hA000_0000};
    req_operands_i[1] = {32'hB000_0001, 32'hA000_0001};
    req_is_boxed_i    = 4'b1111;
    req_rnd_mode_i[0] = RNE;
    req_rnd_mode_i[1] = RDN;
    req_op_i[0]       = SGNJ;
    req_op_i[1]       = CMP;
    req_op_mod_i      = 2'b00;
    unit_in_ready_i   = 1'b0;
    unit_result_i     = '0;
    unit_status_i     = '0;
    unit_ext_bit_i    = 1'b0;
    unit_class_mask_i = POSZERO;
    unit_is_class_i   = 1'b0;
    unit_tag_i        = 1'b0;
    unit_out_valid_i  = 1'b0;
    rsp_ready_i       = 2'b00;

    repeat (2) tick();
    rst_ni = 1'b1;

    // one issue of req0 so reset arrives with state live (cnt=1, rr=1)
    req_valid_i     = 2'b01;
    unit_in_ready_i = 1'b1;
    tick();
    chk("busy_before_reset", 32'(busy_o), 32'd1);

    rst_ni           = 1'b0;
    req_valid_i      = 2'b11;
    unit_out_valid_i = 1'b1;
    rsp_ready_i      = 2'b11;
    #1;
    chk("rst_in_valid", 32'(unit_in_valid_o), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_req_ready", 32'(req_ready_o), 32'd0);
    tick();
    unit_out_valid_i = 1'b0;
    rst_ni           = 1'b1;
    #1;
    chk("first_gnt_tag", 32'(unit_tag_o), 32'd0);
    chk("first_gnt_ready", 32'(req_ready_o), 32'd1);
    chk("first_gnt_valid", 32'(unit_in_valid_o), 32'd1);
    tick();

    // fairness: retire one per cycle so credits stay at 1
    for (int i = 0; i < 3; i++) begin
      unit_out_valid_i = 1'b1;
      unit_tag_i       = 1'b0;
      exp_tag          = (i % 2 == 0) ? 32'd1 : 32'd0;
      #1;
      chk("fair_tag", 32'(unit_tag_o), exp_tag);
      chk("fair_ready", 32'(req_ready_o), 32'd1 << exp_tag);
      chk("fair_opa", unit_operands_o[0], 32'hA000_0000 + exp_tag);
      tick();
    end
    req_valid_i = 2'b00;
    tick();
    unit_out_valid_i = 1'b0;
    #1;
    chk("drain_busy", 32'(busy_o), 32'd0);

    // lock: rr=0 now, req1 alone under backpressure, then req0 joins
    req_valid_i     = 2'b10;
    unit_in_ready_i = 1'b0;
    #1;
    chk("lock_c1_valid", 32'(unit_in_valid_o), 32'd1);
    chk("lock_c1_tag", 32'(unit_tag_o), 32'd1);
    chk("lock_c1_ready", 32'(req_ready_o), 32'd0);
    tick();
    req_valid_i = 2'b11;
    #1;
    chk("lock_c2_tag", 32'(unit_tag_o), 32'd1);
    chk("lock_c2_busy", 32'(busy_o), 32'd1);
    chk("lock_c2_ready", 32'(req_ready_o), 32'd0);
    tick();
    chk("lock_c3_tag", 32'(unit_tag_o), 32'd1);
    tick();
    unit_in_ready_i = 1'b1;
    #1;
    chk("lock_rel_ready", 32'(req_ready_o), 32'b10);
    chk("lock_rel_tag", 32'(unit_tag_o), 32'd1);
    tick();
    req_valid_i = 2'b01;
    #1;
    chk("lock_next_tag", 32'(unit_tag_o), 32'd0);
    req_valid_i      = 2'b00;
    unit_out_valid_i = 1'b1;
    unit_tag_i       = 1'b1;
    tick();
    unit_out_valid_i = 1'b0;

    // credit: four issues, fifth blocked until a retire lands
    req_valid_i = 2'b01;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("credit_issue_ready", 32'(req_ready_o), 32'd1);
      tick();
    end
    chk("credit_block_valid", 32'(unit_in_valid_o), 32'd0);
    chk("credit_block_ready", 32'(req_ready_o), 32'd0);
    tick();
    unit_out_valid_i = 1'b1;
    unit_tag_i       = 1'b0;
    #1;
    chk("credit_no_bypass", 32'(req_ready_o), 32'd0);
    tick();
    unit_out_valid_i = 1'b0;
    #1;
    chk("credit_5th_valid", 32'(unit_in_valid_o), 32'd1);
    chk("credit_5th_ready", 32'(req_ready_o), 32'd1);
    tick();
    req_valid_i = 2'b00;

    // routing: CMP FEQ result for requester 1 held by its backpressure
    unit_out_valid_i = 1'b1;
    unit_tag_i       = 1'b1;
    unit_result_i    = 32'd1;
    unit_status_i    = '{NV: 1'b1, default: 1'b0};
    rsp_ready_i      = 2'b01;
    #1;
    chk("route_out_ready_hold", 32'(unit_out_ready_o), 32'd0);
    chk("route_rsp_valid", 32'(rsp_valid_o), 32'b10);
    chk("route_result", rsp_result_o, 32'd1);
    chk("route_status", 32'(rsp_status_o), 32'h10);
    tick();
    rsp_ready_i = 2'b11;
    #1;
    chk("route_out_ready", 32'(unit_out_ready_o), 32'd1);
    tick();
    unit_out_valid_i = 1'b0;

    // flush with cnt=3 and a lock on req1 (rr=1)
    req_valid_i     = 2'b10;
    unit_in_ready_i = 1'b0;
    tick();
    chk("flush_pre_busy", 32'(busy_o), 32'd1);
    flush_i         = 1'b1;
    unit_in_ready_i = 1'b1;
    #1;
    chk("flush_in_valid", 32'(unit_in_valid_o), 32'd0);
    chk("flush_req_ready", 32'(req_ready_o), 32'd0);
    tick();
    flush_i         = 1'b0;
    req_valid_i     = 2'b00;
    unit_in_ready_i = 1'b0;
    #1;
    chk("flush_busy", 32'(busy_o), 32'd0);
    req_valid_i     = 2'b11;
    unit_in_ready_i = 1'b1;
    #1;
    chk("flush_rr_kept", 32'(unit_tag_o), 32'd1);
`ifdef FPNEW_NONCOMP_SCHED_STATS_EN
    chk("stats_grant0", 32'(grant_cnt_o[0]), 32'd7);
    chk("stats_grant1", 32'(grant_cnt_o[1]), 32'd3);
    chk("stats_stall", 32'(stall_cnt_o), 32'd2);
`endif
    req_valid_i = 2'b00;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
